// File: rtl/seq_multiplier_32bits_if.sv
// Purpose: request/response bundle between the EX stage and the sequential multiplier.
// Latency: wires only, no storage.
// Backpressure: none here; the master must wait for busy=0 before issuing a new start.
// Optional MUL_FLUSH_EN adds the flush request line.
interface seq_multiplier_32bits_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;
`ifdef MUL_FLUSH_EN
    logic        flush;

    modport master (output start, op, rs1, rs2, flush, input busy, done, result);
    modport slave  (input start, op, rs1, rs2, flush, output busy, done, result);
`else
    modport master (output start, op, rs1, rs2, input busy, done, result);
    modport slave  (input start, op, rs1, rs2, output busy, done, result);
`endif
endinterface

// File: rtl/seq_multiplier_32bits.sv
// Purpose: RV32M MUL/MULH/MULHSU/MULHU via radix-2 shift-add on one 32b adder.
// Latency: done pulses in the cycle after edge N+33 for a start sampled at edge N.
// Backpressure: busy=1 from acceptance to the done cycle; starts seen while busy are dropped.
// Optional MUL_FLUSH_EN adds a flush request that abandons an operation in flight.

// Plain ripple-free 32b adder with carry out; kept as its own unit so it can be shared or swapped.
module adder_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {32'd0, ci};
endmodule

module seq_multiplier_32bits #(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_multiplier_32bits_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   mq;
    logic [4:0]        count;
    logic              neg;
    logic              flush_req;

    logic              rs1_neg;
    logic              rs2_neg;
    logic [XLEN-1:0]   rs1_abs;
    logic [XLEN-1:0]   rs2_abs;
    logic [XLEN-1:0]   add_b;
    logic [XLEN-1:0]   add_s;
    logic              add_co;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod64;
    logic              neg_eff;

`ifdef MUL_FLUSH_EN
    assign flush_req = bus.flush;
`else
    assign flush_req = 1'b0;
`endif

    // Operand conditioning: rs1 is signed for MULH/MULHSU, rs2 only for MULH.
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign rs1_neg = ((bus.op == 2'b01) || (bus.op == 2'b10)) && bus.rs1[XLEN-1];
    assign rs2_neg = (bus.op == 2'b01) && bus.rs2[XLEN-1];
    assign rs1_abs = rs1_neg ? (~bus.rs1 + 1'b1) : bus.rs1;
    assign rs2_abs = rs2_neg ? (~bus.rs2 + 1'b1) : bus.rs2;

    // One partial-product add per cycle; the carry becomes bit 63 after the shift.
    assign add_b = mq[0] ? mcand : '0;

    adder_32bits u_adder (
        .a  (acc_hi),
        .b  (add_b),
        .ci (1'b0),
        .s  (add_s),
        .co (add_co)
    );

    // Sign fix-up of the unsigned product; a zero product is never negated.
    assign prod    = {acc_hi, mq};
    assign neg_eff = neg && (prod != '0);
    assign prod64  = neg_eff ? (~prod + 1'b1) : prod;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush abandons any non-idle state, start in IDLE always wins.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (flush_req) state_nxt = IDLE;
                     else if (count == 5'd31) state_nxt = SIGN;
            SIGN:    state_nxt = flush_req ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy covers the whole operation, done only the final cycle.
    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE) && !flush_req;
    end

    // Datapath: operand capture, shift-add iterations and result write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= 2'b00;
            mcand      <= '0;
            acc_hi     <= '0;
            mq         <= '0;
            count      <= '0;
            neg        <= 1'b0;
            bus.result <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op_q   <= bus.op;
                    mcand  <= rs1_abs;
                    mq     <= rs2_abs;
                    neg    <= rs1_neg ^ rs2_neg;
                    acc_hi <= '0;
                    count  <= '0;
                end
                CALC: if (!flush_req) begin
                    acc_hi <= {add_co, add_s[XLEN-1:1]};
                    mq     <= {add_s[0], mq[XLEN-1:1]};
                    count  <= count + 5'd1;
                end
                SIGN: if (!flush_req) begin
                    bus.result <= (op_q == 2'b00) ? prod64[XLEN-1:0] : prod64[2*XLEN-1:XLEN];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier_32bits.sv
// Purpose: directed checks of the sequential multiplier against hand-computed products.
// Latency: expects done 33 edges after the accepting edge and busy for 34 cycles.
// Backpressure: exercises ignored starts while busy, mid-operation reset and (optionally) flush.
module tb_seq_multiplier_32bits;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    seq_multiplier_32bits_if mif ();

    seq_multiplier_32bits dut (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, act, exp);
        end
    endtask

    // Issues one operation and watches 40 cycles after the accepting edge N.
    // start2_k / rst_k >= 0 inject a second start or a reset sampled at edge N+k+1.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int start2_k, input int rst_k,
                          output logic [31:0] res, output int lat, output int bcnt, output int dcnt);
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = o;
        mif.rs1   = a;
        mif.rs2   = b;
        @(posedge clk);
        lat  = -1;
        bcnt = 0;
        dcnt = 0;
        res  = 32'hBAD0_BAD0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mif.busy) bcnt++;
            if (mif.done) begin
                dcnt++;
                if (lat < 0) begin
                    lat = k;
                    res = mif.result;
                end
            end
            if (k == 0) begin
                mif.start = 1'b0;
                mif.op    = ~o;
                mif.rs1   = 32'hDEAD_BEEF;
                mif.rs2   = 32'h1234_5678;
`ifdef MUL_FLUSH_EN
                mif.flush = 1'b0;
`endif
            end
            mif.start = (k == start2_k);
            if (k == rst_k) rst = 1'b1;
            if (k == rst_k + 1) rst = 1'b0;
        end
        if (lat < 0) res = mif.result;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] res;
        int lat;
        int bcnt;
        int dcnt;

        vecs[0]  = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
        vecs[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        vecs[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[6]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[7]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[8]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1};
        vecs[9]  = '{2'b11, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[10] = '{2'b01, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000};
        vecs[11] = '{2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[12] = '{2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001};
        vecs[13] = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
        vecs[14] = '{2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
        vecs[15] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};

        mif.start = 1'b0;
        mif.op    = 2'b00;
        mif.rs1   = '0;
        mif.rs2   = '0;
`ifdef MUL_FLUSH_EN
        mif.flush = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, mif.busy}, 32'd0);
        chk("rst_done", {31'd0, mif.done}, 32'd0);
        chk("rst_result", mif.result, 32'd0);
        rst = 1'b0;

        // Main function over all op codes and operand corners.
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, -1, res, lat, bcnt, dcnt);
            chk($sformatf("v%0d_result", i), res, vecs[i].exp);
            chk($sformatf("v%0d_latency", i), lat, 32'd33);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, 32'd34);
            chk($sformatf("v%0d_done_cycles", i), dcnt, 32'd1);
        end

        // Start at N+5 while busy is ignored; the first result stands.
        run_op(2'b00, 32'd7, 32'd6, 4, -1, res, lat, bcnt, dcnt);
        chk("ign_result", res, 32'h0000_002A);
        chk("ign_latency", lat, 32'd33);
        chk("ign_done_cycles", dcnt, 32'd1);

        // Reset at N+10 aborts with no done and clears result.
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 9, res, lat, bcnt, dcnt);
        chk("rst_mid_done_cycles", dcnt, 32'd0);
        chk("rst_mid_busy_cycles", bcnt, 32'd10);
        chk("rst_mid_result", res, 32'd0);

`ifdef MUL_FLUSH_EN
        run_op(2'b00, 32'd7, 32'd6, -1, -1, res, lat, bcnt, dcnt);
        chk("pre_flush_result", res, 32'h0000_002A);

        // Flush sampled at N+12: idle next edge, no done, result unchanged.
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = 2'b00;
        mif.rs1   = 32'd9;
        mif.rs2   = 32'd9;
        @(posedge clk);
        bcnt = 0;
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mif.busy) bcnt++;
            if (mif.done) dcnt++;
            mif.start = 1'b0;
            mif.flush = (k == 11);
        end
        chk("flush_busy_cycles", bcnt, 32'd12);
        chk("flush_done_cycles", dcnt, 32'd0);
        chk("flush_result", mif.result, 32'h0000_002A);

        // Flush held in IDLE together with start: start is still accepted.
        mif.flush = 1'b1;
        run_op(2'b00, 32'd3, 32'd5, -1, -1, res, lat, bcnt, dcnt);
        chk("post_flush_result", res, 32'h0000_000F);
        chk("post_flush_latency", lat, 32'd33);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
